// File: rtl/macc_accumulator.sv
// macc_accumulator: running-sum reduction stage fed by the macc PE.
// Ports: start/num_iter, in_valid/in_data/in_ready, sum_fb, out_*, busy, sat_flag.
module macc_accumulator #(
  parameter int INTER_BITWIDTH = 65,
  parameter int SUM_BITWIDTH   = 64,
  parameter int CNT_BITWIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [CNT_BITWIDTH-1:0]   num_iter,
  input  logic                      in_valid,
  input  logic [INTER_BITWIDTH-1:0] in_data,
  output logic                      in_ready,
  output logic [SUM_BITWIDTH-1:0]   sum_fb,
  output logic                      out_valid,
  output logic [SUM_BITWIDTH-1:0]   out_data,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      sat_flag
);

  localparam int HI_W = INTER_BITWIDTH - SUM_BITWIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [SUM_BITWIDTH-1:0]   acc_q, acc_d;
  logic [CNT_BITWIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_BITWIDTH-1:0]   len_q, len_d;
  logic                      sat_q, sat_d;

  logic [HI_W-1:0]           hi_bits;
  logic                      ovf;
  logic                      ovf_pos;
  logic                      ovf_neg;
  logic [SUM_BITWIDTH-1:0]   sat_val;

  // Value fits when every bit from the result sign upward agrees.
  assign hi_bits = in_data[INTER_BITWIDTH-1:SUM_BITWIDTH-1];
  assign ovf     = !((&hi_bits) || !(|hi_bits));
  assign ovf_pos = ovf && !in_data[INTER_BITWIDTH-1];
  assign ovf_neg = ovf && in_data[INTER_BITWIDTH-1];

  always_comb begin
    sat_val = in_data[SUM_BITWIDTH-1:0];
    unique case (1'b1)
      ovf_pos: sat_val = {1'b0, {(SUM_BITWIDTH-1){1'b1}}};
      ovf_neg: sat_val = {1'b1, {(SUM_BITWIDTH-1){1'b0}}};
      default: sat_val = in_data[SUM_BITWIDTH-1:0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    sat_d     = sat_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          len_d   = num_iter;
          sat_d   = 1'b0;
          state_d = (num_iter != '0) ? ACCUM : DRAIN;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = sat_val;
          cnt_d = cnt_q + CNT_BITWIDTH'(1);
          if (ovf) begin
            sat_d = 1'b1;
          end
          // Terminal compare against the latched length; cnt never wraps.
          if (cnt_q == len_q - CNT_BITWIDTH'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sat_q   <= sat_d;
    end
  end

  // acc only changes in ACCUM, so out_data is stable throughout DRAIN.
  assign sum_fb   = acc_q;
  assign out_data = acc_q;
  assign busy     = (state_q != IDLE);
  assign sat_flag = sat_q;

endmodule

// File: doc/macc_accumulator.md
# macc_accumulator

Sequential reduction stage directly downstream of the combinational `macc` PE. It holds the running partial sum and feeds it back as the `macc` `sum_in` operand. Each cycle it captures the 65-bit `macc` result, saturates it to 64 bits and counts accepted elements. After a programmed reduction length it presents the final sum on a valid/ready output toward the output buffer.

## Interface
- `INTER_BITWIDTH`, 65, width of the incoming `macc` result (signed)
- `SUM_BITWIDTH`, 64, width of the partial-sum register, feedback and result (signed)
- `CNT_BITWIDTH`, 16, width of the reduction-length field and element counter

Ports:
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse that begins a reduction; honoured only in IDLE
- `num_iter`  in  CNT_BITWIDTH  reduction length, sampled when `start` is accepted
- `in_valid`  in  1  a `macc` result is present
- `in_data`  in  INTER_BITWIDTH  `macc` output (product + `sum_fb`), signed
- `in_ready`  out  1  accumulator accepts `in_data` this cycle
- `sum_fb`  out  SUM_BITWIDTH  current partial sum, wired to `macc` `sum_in`
- `out_valid`  out  1  final sum available
- `out_data`  out  SUM_BITWIDTH  final sum, signed
- `out_ready`  in  1  downstream consumes `out_data`
- `busy`  out  1  high in any state other than IDLE
- `sat_flag`  out  1  sticky: saturation occurred in the current or most recent reduction

## Operation
- State machine has three states: IDLE, ACCUM and DRAIN.
- IDLE:
  - `in_ready`=0, `out_valid`=0.
  - On `start`: the accumulator register is cleared to 0, the counter is cleared to 0, `num_iter` is latched and `sat_flag` is cleared.
  - The next state is ACCUM if `num_iter`≠0, otherwise DRAIN, which emits a result of 0.
- ACCUM:
  - `in_ready`=1.
  - On `in_valid`: acc ← sat(`in_data`) and cnt ← cnt+1.
  - When the accepted element is number `num_iter` (cnt == latched−1 at acceptance), the next state is DRAIN.
  - Cycles without `in_valid` are stalls; acc and cnt hold.
- DRAIN:
  - `out_valid`=1, `out_data`=acc, `in_ready`=0.
  - On `out_ready` the next state is IDLE. `out_data` holds stable while `out_valid` && !`out_ready`.
- `sum_fb` = acc in every state. In IDLE it holds the last result until the next `start` clears it.
- Saturation: `in_data` is treated as signed 65-bit.
  - Values > 2^63−1 clamp to 0x7FFF_FFFF_FFFF_FFFF.
  - Values < −2^63 clamp to 0x8000_0000_0000_0000.
  - Otherwise the lower 64 bits pass through unchanged.
  - Any clamp sets `sat_flag`, which holds until the next accepted `start`.
- A `start` in ACCUM or DRAIN is ignored; it has no effect on state, counter or latched length.
- `busy` = (state ≠ IDLE).
- The counter never wraps: the maximum length is 2^CNT_BITWIDTH−1, and the terminal compare uses the latched value.

## Timing
- Reset (async assert, synchronous-safe deassert handled upstream): state=IDLE, acc=0, cnt=0, latched length=0, `sat_flag`=0. Consequently `in_ready`=0, `out_valid`=0, `out_data`=0, `sum_fb`=0, `busy`=0.
- Reset asserted mid-reduction aborts immediately. No partial result is emitted.
- `start` accepted at edge T: `busy`=1 and `in_ready`=1 from T+1 (or `out_valid`=1 from T+1 when `num_iter`=0).
- `in_data` is registered; `sum_fb` updates the cycle after each acceptance. The `macc` loop is therefore one element per cycle with no bubbles.
- Latency: the last element is accepted at edge T and `out_valid`=1 from T+1. For N elements with no stalls, the result appears N+1 cycles after `start`.
- Output handshake completes on the edge where `out_valid`&&`out_ready`. `busy`=0 and `out_valid`=0 from the next cycle. A new `start` can be accepted in that first IDLE cycle.
- `in_ready` and `out_valid` are never high in the same cycle.

## Test plan
- Reset mid-ACCUM after 3 of 8 elements → all outputs 0 the same cycle, no `out_valid`, next `start` behaves normally.
- `start`, `num_iter`=4, and `macc` driven with products 2,3,−1,5 (in_data = sum_fb + p) → `out_data`=9 at cycle 5, `sat_flag`=0, `sum_fb` sequence 0,2,5,4,9.
- `num_iter`=3 with `in_valid` deasserted for 2 cycles between elements → acc and cnt hold during the stalls; final sum correct; `out_valid` one cycle after the third acceptance.
- `in_data` = 2^63 + 5, then −2^64+1 in a 2-element reduction → first clamps to 0x7FFF…FFFF, second clamps to 0x8000…0000, `sat_flag`=1; `sat_flag` clears on the next `start`.
- `num_iter`=0 → `out_valid`=1 with `out_data`=0 the cycle after `start`, `in_ready` never asserts.
- `out_ready` held low for 5 cycles in DRAIN with `start` pulsed meanwhile → `out_data` stable, `start` ignored, IDLE entered after the handshake, back-to-back `start` accepted the following cycle.
